// File: rtl/serial_bcd_alu_core_pkg.sv
// Shared types and widths for the bit-serial BCD add/subtract core.
package serial_bcd_alu_core_pkg;
  localparam int DIGITS = 4;
  localparam int OPW    = 4*DIGITS;
  localparam int RESW   = 4*(DIGITS+1);
  localparam int FRAME  = 2*OPW+1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {IDLE, LOAD, CALC, OUT, DONE} state_e;
endpackage

// File: rtl/bcd_digit_adder.sv
// One BCD digit add with carry: binary sum, then +6 when it leaves 0..9.
module bcd_digit_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] raw;

  assign raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
  assign c_o = (raw > 5'd9);
  assign s_o = c_o ? raw[3:0] + 4'd6 : raw[3:0];
endmodule

// File: rtl/serial_bcd_alu_core.sv
// Bit-serial BCD add/subtract: 33-bit frame in (A, B, opcode), 20-bit result out LSB-first.
module serial_bcd_alu_core
  import serial_bcd_alu_core_pkg::*;
#(
  parameter int DIGITS = serial_bcd_alu_core_pkg::DIGITS
) (
  input  logic rst,
  input  logic clk,
  input  logic en,
  input  logic in,
  output logic result
);
  localparam int OW = 4*DIGITS;
  localparam int RW = 4*(DIGITS+1);
  localparam int FW = 2*OW+1;
  localparam int CW = $clog2(FW+1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*OW-1:0]   op_sh_q;
  logic              op_q;
  logic [RW-1:0]     res_sh_q;
  logic              result_q;

  logic [OW-1:0]     a_w, b_w, b_eff, sum;
  logic [DIGITS:0]   cy;
  logic [3:0]        top_dig;
  logic [RW-1:0]     res_d;

  // Operands shift in at the MSB, so after 2*OW bits A sits in the low half.
  assign a_w   = op_sh_q[OW-1:0];
  assign b_w   = op_sh_q[2*OW-1:OW];
  assign cy[0] = (op_q == OP_SUB);

  // Subtraction adds the nines' complement of B with carry-in 1.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign b_eff[4*g +: 4] = (op_q == OP_SUB) ? 4'd9 - b_w[4*g +: 4] : b_w[4*g +: 4];
    bcd_digit_adder u_dig (
      .a_i (a_w[4*g +: 4]),
      .b_i (b_eff[4*g +: 4]),
      .c_i (cy[g]),
      .s_o (sum[4*g +: 4]),
      .c_o (cy[g+1])
    );
  end

  // Top digit: carry for ADD; for SUB no carry out means a borrow -> 9.
  assign top_dig = (op_q == OP_SUB) ? (cy[DIGITS] ? 4'd0 : 4'd9) : {3'b0, cy[DIGITS]};
  assign res_d   = {top_dig, sum};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_sh_q  <= '0;
      op_q     <= OP_ADD;
      res_sh_q <= '0;
      result_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          result_q <= 1'b0;
          if (en) begin
            op_sh_q <= {in, op_sh_q[2*OW-1:1]};
            cnt_q   <= CW'(1);
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (!en) begin
            op_sh_q <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q == CW'(FW-1)) begin
            op_q    <= in;
            cnt_q   <= '0;
            state_q <= CALC;
          end else begin
            op_sh_q <= {in, op_sh_q[2*OW-1:1]};
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        CALC: begin
          res_sh_q <= res_d;
          cnt_q    <= '0;
          state_q  <= OUT;
        end
        OUT: begin
          result_q <= res_sh_q[0];
          res_sh_q <= {1'b0, res_sh_q[RW-1:1]};
          if (cnt_q == CW'(RW-1)) begin
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          result_q <= 1'b0;
          if (!en) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
endmodule

// File: tb/tb_serial_bcd_alu_core.sv
// Directed bench for serial_bcd_alu_core: hand-computed BCD results per scenario.
module tb_serial_bcd_alu_core;
  logic rst, clk, en, in, result;
  int   tests = 0;
  int   fails = 0;

  serial_bcd_alu_core #(.DIGITS(4)) dut (
    .rst    (rst),
    .clk    (clk),
    .en     (en),
    .in     (in),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one full frame and deserialises the 20-bit window; counts nonzero result outside it.
  task automatic run_frame(input logic [15:0] a, input logic [15:0] b, input logic op,
                           input bit hold, output logic [19:0] r, output int stray);
    logic [32:0] f;
    f = {op, b, a};
    stray = 0;
    r = '0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (result !== 1'b0) stray++;
      en = 1'b1;
      in = f[i];
    end
    @(negedge clk);
    if (result !== 1'b0) stray++;
    en = hold;
    in = hold;
    @(negedge clk);
    if (result !== 1'b0) stray++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r[i] = result;
      if (hold) in = ~in;
    end
    @(negedge clk);
    if (result !== 1'b0) stray++;
    en = 1'b0;
    @(negedge clk);
    if (result !== 1'b0) stray++;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; in = 1'b0;
    #3;
    tests++;
    if (result !== 1'b0) begin
      $display("FAIL reset_result got %b exp 0", result); fails++;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (result !== 1'b0) begin
      $display("FAIL reset_release got %b exp 0", result); fails++;
    end
  endtask

  task automatic test_add;
    logic [19:0] r; int s;
    run_frame(16'h6956, 16'h8678, 1'b0, 1'b0, r, s);
    tests++;
    if (r !== 20'h15634) begin $display("FAIL add_6956_8678 got %h exp 15634", r); fails++; end
    tests++;
    if (s !== 0) begin $display("FAIL add_window got %0d stray exp 0", s); fails++; end
  endtask

  task automatic test_sub_gap;
    logic [19:0] r; int s;
    repeat (50) @(negedge clk);
    run_frame(16'h4263, 16'h2147, 1'b1, 1'b0, r, s);
    tests++;
    if (r !== 20'h02116) begin $display("FAIL sub_4263_2147 got %h exp 02116", r); fails++; end
    tests++;
    if (s !== 0) begin $display("FAIL sub_window got %0d stray exp 0", s); fails++; end
  endtask

  task automatic test_sub_borrow;
    logic [19:0] r; int s;
    run_frame(16'h2147, 16'h4263, 1'b1, 1'b0, r, s);
    tests++;
    if (r !== 20'h97884) begin $display("FAIL sub_2147_4263 got %h exp 97884", r); fails++; end
    run_frame(16'h5000, 16'h5000, 1'b1, 1'b0, r, s);
    tests++;
    if (r !== 20'h00000) begin $display("FAIL sub_equal got %h exp 00000", r); fails++; end
    tests++;
    if (s !== 0) begin $display("FAIL sub_equal_window got %0d stray exp 0", s); fails++; end
  endtask

  task automatic test_carry;
    logic [19:0] r; int s;
    run_frame(16'h9999, 16'h9999, 1'b0, 1'b0, r, s);
    tests++;
    if (r !== 20'h19998) begin $display("FAIL add_9999_9999 got %h exp 19998", r); fails++; end
    run_frame(16'h0000, 16'h0001, 1'b0, 1'b0, r, s);
    tests++;
    if (r !== 20'h00001) begin $display("FAIL add_0000_0001 got %h exp 00001", r); fails++; end
  endtask

  // en held high through OUT and DONE; the extra bits must not disturb the result.
  task automatic test_back_to_back;
    logic [19:0] r; int s;
    run_frame(16'h0385, 16'h0815, 1'b0, 1'b1, r, s);
    tests++;
    if (r !== 20'h01200) begin $display("FAIL hold_en_add got %h exp 01200", r); fails++; end
    tests++;
    if (s !== 0) begin $display("FAIL hold_en_window got %0d stray exp 0", s); fails++; end
    run_frame(16'h0100, 16'h0999, 1'b1, 1'b0, r, s);
    tests++;
    if (r !== 20'h99101) begin $display("FAIL b2b_sub got %h exp 99101", r); fails++; end
  endtask

  task automatic test_abort;
    logic [19:0] r; int s; int toggles;
    toggles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result !== 1'b0) toggles++;
      en = 1'b1;
      in = i[0] ^ i[2];
    end
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result !== 1'b0) toggles++;
      in = ~in;
    end
    tests++;
    if (toggles !== 0) begin $display("FAIL abort_quiet got %0d nonzero exp 0", toggles); fails++; end
    run_frame(16'h1234, 16'h4321, 1'b0, 1'b0, r, s);
    tests++;
    if (r !== 20'h05555) begin $display("FAIL after_abort got %h exp 05555", r); fails++; end
    tests++;
    if (s !== 0) begin $display("FAIL after_abort_window got %0d stray exp 0", s); fails++; end
  endtask

  // 9999+9999 = 0x19998 has R[7]=1, so the reset drop is visible.
  task automatic test_reset_mid_out;
    logic [32:0] f; logic [7:0] got; logic [19:0] r; int s; int nz;
    f = {1'b0, 16'h9999, 16'h9999};
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      en = 1'b1;
      in = f[i];
    end
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got[i] = result;
    end
    tests++;
    if (got !== 8'h98) begin $display("FAIL pre_reset_bits got %h exp 98", got); fails++; end
    rst = 1'b0;
    #1;
    tests++;
    if (result !== 1'b0) begin $display("FAIL reset_mid_out got %b exp 0", result); fails++; end
    nz = 0;
    repeat (3) begin
      @(negedge clk);
      if (result !== 1'b0) nz++;
    end
    rst = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (result !== 1'b0) nz++;
    end
    tests++;
    if (nz !== 0) begin $display("FAIL post_reset_quiet got %0d nonzero exp 0", nz); fails++; end
    run_frame(16'h4263, 16'h2147, 1'b1, 1'b0, r, s);
    tests++;
    if (r !== 20'h02116) begin $display("FAIL after_reset got %h exp 02116", r); fails++; end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_gap();
    test_sub_borrow();
    test_carry();
    test_back_to_back();
    test_abort();
    test_reset_mid_out();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
